// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO for the pipelined MIPS core.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_exe,
  input  logic [1:0]  op_exe,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush_exe,
  input  logic        mthi_exe,
  input  logic        mtlo_exe,
  input  logic        mfhilo_decode,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_muldiv,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_op;
  logic        r_sign_rs;
  logic        r_sign_rt;
  logic [31:0] r_rs_raw;
  logic [4:0]  r_cnt;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_divisor;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_div_zero;

  logic        w_accept;
  logic        w_mt_ok;
  logic        w_in_signed;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_abs;
  logic [31:0] w_rt_abs;
  logic        w_is_div;
  logic        w_is_signed;
  logic        w_last;
  logic [63:0] w_acc_sum;
  logic [32:0] w_trial;
  logic        w_fits;
  logic [31:0] w_diff;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  assign w_accept    = start_exe & ~r_busy & ~flush_exe;
  assign w_mt_ok     = ~r_busy & ~flush_exe;
  assign w_in_signed = ~op_exe[0];
  assign w_rs_neg    = w_in_signed & rs_val[31];
  assign w_rt_neg    = w_in_signed & rt_val[31];
  assign w_rs_abs    = w_rs_neg ? (~rs_val + 32'd1) : rs_val;
  assign w_rt_abs    = w_rt_neg ? (~rt_val + 32'd1) : rt_val;

  assign w_is_div    = r_op[1];
  assign w_is_signed = ~r_op[0];

  assign w_acc_sum   = r_acc + (r_mplier[0] ? r_mcand : 64'd0);

  // Restoring divide: the dividend shifts out of r_quot MSB-first while quotient bits shift in.
  assign w_trial     = {r_rem, r_quot[31]};
  assign w_fits      = (w_trial >= {1'b0, r_divisor});
  assign w_diff      = w_trial[31:0] - r_divisor;

`ifdef MULDIV_EARLY_OUT_EN
  assign w_last = (r_cnt == 5'd31) | (~w_is_div & (r_mplier[31:1] == 31'd0));
`else
  assign w_last = (r_cnt == 5'd31);
`endif

  // Sign correction and divide-by-zero override applied at the FIX edge.
  always_comb begin
    w_fix_hi = r_acc[63:32];
    w_fix_lo = r_acc[31:0];
    if (w_is_div) begin
      if (r_div_zero) begin
        w_fix_hi = r_rs_raw;
        w_fix_lo = 32'hFFFF_FFFF;
      end else begin
        w_fix_hi = (w_is_signed & r_sign_rs) ? (~r_rem + 32'd1) : r_rem;
        w_fix_lo = (w_is_signed & (r_sign_rs ^ r_sign_rt)) ? (~r_quot + 32'd1) : r_quot;
      end
    end else if (w_is_signed & (r_sign_rs ^ r_sign_rt)) begin
      {w_fix_hi, w_fix_lo} = ~r_acc + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last)   w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= 2'd0;
      r_sign_rs  <= 1'b0;
      r_sign_rt  <= 1'b0;
      r_rs_raw   <= 32'd0;
      r_cnt      <= 5'd0;
      r_mcand    <= 64'd0;
      r_mplier   <= 32'd0;
      r_acc      <= 64'd0;
      r_rem      <= 32'd0;
      r_quot     <= 32'd0;
      r_divisor  <= 32'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_busy     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= op_exe;
            r_sign_rs  <= w_rs_neg;
            r_sign_rt  <= w_rt_neg;
            r_rs_raw   <= rs_val;
            r_cnt      <= 5'd0;
            r_mcand    <= {32'd0, w_rs_abs};
            r_mplier   <= w_rt_abs;
            r_acc      <= 64'd0;
            r_rem      <= 32'd0;
            r_quot     <= w_rs_abs;
            r_divisor  <= w_rt_abs;
            r_busy     <= 1'b1;
            r_div_zero <= op_exe[1] & (rt_val == 32'd0);
          end
          if (w_mt_ok & mthi_exe) r_hi <= rs_val;
          if (w_mt_ok & mtlo_exe) r_lo <= rs_val;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_is_div) begin
            r_rem  <= w_fits ? w_diff : w_trial[31:0];
            r_quot <= {r_quot[30:0], w_fits};
          end else begin
            r_acc    <= w_acc_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        S_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_busy <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign hi           = r_hi;
  assign lo           = r_lo;
  assign busy         = r_busy;
  assign div_zero     = r_div_zero;
  assign stall_muldiv = r_busy & (start_exe | mthi_exe | mtlo_exe | mfhilo_decode);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table of mul/div results plus stall/reset/flush sequences.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_exe;
  logic [1:0]  op_exe;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush_exe;
  logic        mthi_exe;
  logic        mtlo_exe;
  logic        mfhilo_decode;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_muldiv;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDz;
  } vec_t;

  vec_t vecs[12];

  muldiv_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_exe     (start_exe),
    .op_exe        (op_exe),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .flush_exe     (flush_exe),
    .mthi_exe      (mthi_exe),
    .mtlo_exe      (mtlo_exe),
    .mfhilo_decode (mfhilo_decode),
    .hi            (hi),
    .lo            (lo),
    .busy          (busy),
    .stall_muldiv  (stall_muldiv),
    .div_zero      (div_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int expBusy(input logic [1:0] op, input logic [31:0] rt);
    int n;
    logic [31:0] a;
    n = 33;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      a = (!op[0] && rt[31]) ? (~rt + 32'd1) : rt;
      n = 2;
      for (int b = 0; b < 32; b++) if (a[b]) n = b + 2;
    end
`else
    a = rt;
    if (op[1] && a == 32'd0) n = 33;
`endif
    return n;
  endfunction

  // Issues one op, releases start after the accept edge and counts the busy cycles.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                               output int cycles);
    start_exe = 1'b1;
    op_exe    = op;
    rs_val    = rs;
    rt_val    = rt;
    tick();
    start_exe = 1'b0;
    cycles    = 0;
    while (busy && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    int cyc;
    int stallBad;
    int hiBad;

    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[5]  = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[6]  = '{OP_MULT,  32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[7]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{OP_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{OP_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0019, 1'b0};
    vecs[10] = '{OP_MULTU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{OP_MULTU, 32'h0000_0003, 32'h0000_0001, 32'h0000_0000, 32'h0000_0003, 1'b0};

    rst_n = 1'b0; start_exe = 1'b0; op_exe = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
    flush_exe = 1'b0; mthi_exe = 1'b0; mtlo_exe = 1'b0; mfhilo_decode = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_dz", 64'(div_zero), 64'd0);
    checkOutput("reset_stall", 64'(stall_muldiv), 64'd0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
      checkOutput($sformatf("vec%0d_busy_cycles", i), 64'(cyc), 64'(expBusy(vecs[i].op, vecs[i].rt)));
      checkOutput($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].expHi));
      checkOutput($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].expLo));
      checkOutput($sformatf("vec%0d_dz", i), 64'(div_zero), 64'(vecs[i].expDz));
    end

    // MFHI waiting in DECODE behind a running multiply.
    mthi_exe = 1'b1; rs_val = 32'h0000_AAAA;
    tick();
    mthi_exe = 1'b0;
    checkOutput("mthi_idle_write", 64'(hi), 64'h0000_AAAA);
    start_exe = 1'b1; op_exe = OP_MULTU; rs_val = 32'd5; rt_val = 32'd6;
    tick();
    start_exe = 1'b0; mfhilo_decode = 1'b1;
    stallBad = 0; hiBad = 0; cyc = 0;
    while (busy && cyc < 200) begin
      #1;
      if (stall_muldiv !== 1'b1) stallBad++;
      if (hi !== 32'h0000_AAAA) hiBad++;
      cyc++;
      tick();
    end
    #1;
    checkOutput("mfhi_stall_while_busy", 64'(stallBad), 64'd0);
    checkOutput("hi_stable_during_run", 64'(hiBad), 64'd0);
    checkOutput("mfhi_stall_at_fall", 64'(stall_muldiv), 64'd0);
    checkOutput("mfhi_sees_new_hi", 64'(hi), 64'd0);
    checkOutput("mfhi_seq_lo", 64'(lo), 64'd30);
    mfhilo_decode = 1'b0;

    // Second MULTU re-presented while busy; accepted in the busy-fall cycle.
    start_exe = 1'b1; op_exe = OP_MULTU; rs_val = 32'd2; rt_val = 32'd3;
    tick();
    rs_val = 32'd4; rt_val = 32'd5;
    stallBad = 0; cyc = 0;
    while (busy && cyc < 200) begin
      #1;
      if (stall_muldiv !== 1'b1) stallBad++;
      cyc++;
      tick();
    end
    #1;
    checkOutput("b2b_stall_while_busy", 64'(stallBad), 64'd0);
    checkOutput("b2b_stall_at_fall", 64'(stall_muldiv), 64'd0);
    checkOutput("b2b_first_lo", 64'(lo), 64'd6);
    tick();
    start_exe = 1'b0;
    checkOutput("b2b_second_accepted", 64'(busy), 64'd1);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      tick();
    end
    checkOutput("b2b_second_lo", 64'(lo), 64'd20);

    // MTLO held off by the engine, then written once idle.
    start_exe = 1'b1; op_exe = OP_MULTU; rs_val = 32'd1; rt_val = 32'd1;
    tick();
    start_exe = 1'b0; mtlo_exe = 1'b1; rs_val = 32'h0000_1234;
    stallBad = 0; cyc = 0;
    while (busy && cyc < 200) begin
      #1;
      if (stall_muldiv !== 1'b1) stallBad++;
      cyc++;
      tick();
    end
    checkOutput("mtlo_stall_while_busy", 64'(stallBad), 64'd0);
    checkOutput("mtlo_not_yet_written", 64'(lo), 64'd1);
    tick();
    mtlo_exe = 1'b0;
    checkOutput("mtlo_written_after_fix", 64'(lo), 64'h0000_1234);

    // Synchronous reset in the middle of RUN.
    start_exe = 1'b1; op_exe = OP_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
    tick();
    start_exe = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    checkOutput("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrun_reset_busy", 64'(busy), 64'd0);
    checkOutput("midrun_reset_hi", 64'(hi), 64'd0);
    checkOutput("midrun_reset_lo", 64'(lo), 64'd0);

    // Flushed start and flushed MTHI must leave everything untouched.
    flush_exe = 1'b1; start_exe = 1'b1; mthi_exe = 1'b1;
    op_exe = OP_MULTU; rs_val = 32'd3; rt_val = 32'd3;
    tick();
    flush_exe = 1'b0; start_exe = 1'b0; mthi_exe = 1'b0;
    checkOutput("flush_no_accept", 64'(busy), 64'd0);
    checkOutput("flush_no_mthi", 64'(hi), 64'd0);
    tick();
    checkOutput("flush_still_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
